// File: rtl/mul_div_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_pkg
// Shared types and constants for the iterative multiply/divide unit:
//   DEFAULT_WIDTH - default operand/result width
//   op_e          - operation encoding carried on the op port
//   state_e       - sequencer states (IDLE -> PREP -> CALC -> FIX)
//   is_signed / is_div - decode helpers on op_e
// ---------------------------------------------------------------------------
package mul_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_DIVU  = 2'b01,
        OP_MULT  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_CALC = 2'b10,
        ST_FIX  = 2'b11
    } state_e;

    // Bit 1 of the op encoding selects two's-complement operands.
    function automatic logic is_signed(input op_e op);
        return op[1];
    endfunction

    // Bit 0 of the op encoding selects divide over multiply.
    function automatic logic is_div(input op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if
// Request/result bundle of mul_div_unit.
//   master: drives start, op, in1, in2; observes busy, done, lo, hi, dbz,
//           ovf, z
//   slave : the unit itself (mirror directions)
// ---------------------------------------------------------------------------
interface mul_div_unit_if #(
    parameter int WIDTH = mul_div_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             dbz;
    logic             ovf;
    logic             z;

    modport master (
        output start, op, in1, in2,
        input  busy, done, lo, hi, dbz, ovf, z
    );

    modport slave (
        input  start, op, in1, in2,
        output busy, done, lo, hi, dbz, ovf, z
    );
endinterface

// File: rtl/mul_div_negate.sv
// ---------------------------------------------------------------------------
// mul_div_negate
// Conditional two's-complement negate.
//   a_i   - value in
//   neg_i - 1: y_o = -a_i, 0: y_o = a_i
//   y_o   - value out
// ---------------------------------------------------------------------------
module mul_div_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] y_o
);

    // Invert-and-increment when negation is requested, otherwise pass through.
    always_comb begin
        if (neg_i) begin
            y_o = ~a_i + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            y_o = a_i;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Iterative MULTU/MULT/DIVU/DIV unit, one shift-add or restoring-subtract
// step per cycle. Operands are captured on the accepting edge, reduced to
// magnitudes in PREP, iterated WIDTH times in CALC and sign-corrected in FIX.
//   clk  - sole clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - mul_div_unit_if.slave: start/op/in1/in2 in; busy/done/lo/hi/
//          dbz/ovf/z out (all outputs registered)
// Build option: define MUL_DIV_UNIT_DIV_EN to include the divide datapath.
// Without it, ops DIVU/DIV finish two edges after acceptance with lo=hi=0,
// ovf=1, dbz=0.
// ---------------------------------------------------------------------------
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;
    logic               z_q, z_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;        // captured in1
    logic [WIDTH-1:0]   b_q, b_d;        // captured in2
    logic [WIDTH-1:0]   m_q, m_d;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   p_hi_q, p_hi_d;  // product high / partial remainder
    logic [WIDTH-1:0]   p_lo_q, p_lo_d;  // multiplier bits / quotient bits
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_res_q, neg_res_d;

    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH:0]     mul_sum_s;

    mul_div_negate #(.WIDTH(WIDTH)) u_neg_a (
        .a_i   (a_q),
        .neg_i (is_signed(op_q) && a_q[WIDTH-1]),
        .y_o   (mag_a_s)
    );

    mul_div_negate #(.WIDTH(WIDTH)) u_neg_b (
        .a_i   (b_q),
        .neg_i (is_signed(op_q) && b_q[WIDTH-1]),
        .y_o   (mag_b_s)
    );

    mul_div_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .a_i   ({p_hi_q, p_lo_q}),
        .neg_i (neg_res_q),
        .y_o   (prod_fix_s)
    );

    // Add the multiplicand into the high half when the current multiplier
    // bit is set; the extra bit carries into the right shift.
    assign mul_sum_s = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});

`ifdef MUL_DIV_UNIT_DIV_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic [WIDTH:0]     div_trial_s;

    mul_div_negate #(.WIDTH(WIDTH)) u_neg_quo (
        .a_i   (p_lo_q),
        .neg_i (neg_res_q),
        .y_o   (quo_fix_s)
    );

    mul_div_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .a_i   (p_hi_q),
        .neg_i (neg_rem_q),
        .y_o   (rem_fix_s)
    );

    // Shift the next dividend bit into the remainder and trial-subtract;
    // the top bit set means the divisor did not fit (restore).
    assign div_trial_s = {p_hi_q, p_lo_q[WIDTH-1]} - {1'b0, m_q};
`endif

    // Next-state and datapath control for the IDLE/PREP/CALC/FIX sequencer.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        lo_d      = lo_q;
        hi_d      = hi_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        z_d       = z_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        p_hi_d    = p_hi_q;
        p_lo_d    = p_lo_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
`ifdef MUL_DIV_UNIT_DIV_EN
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (busy_q) begin
                    // Early exit from PREP lands here with busy still set so
                    // that done appears one edge later than the exit itself.
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    lo_d   = ZERO_W;
                    hi_d   = ZERO_W;
                    z_d    = 1'b1;
`ifdef MUL_DIV_UNIT_DIV_EN
                    dbz_d  = 1'b1;
                    ovf_d  = 1'b0;
`else
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b1;
`endif
                end else if (bus.start) begin
                    state_d = ST_PREP;
                    busy_d  = 1'b1;
                    op_d    = op_e'(bus.op);
                    a_d     = bus.in1;
                    b_d     = bus.in2;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREP: begin
                neg_res_d = is_signed(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
`ifdef MUL_DIV_UNIT_DIV_EN
                neg_rem_d = is_signed(op_q) && a_q[WIDTH-1];
`endif
                cnt_d     = {CNT_W{1'b0}};
                p_hi_d    = ZERO_W;
                if (is_div(op_q)) begin
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (b_q == ZERO_W) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CALC;
                        m_d     = mag_b_s;
                        p_lo_d  = mag_a_s;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_CALC;
                    m_d     = mag_a_s;
                    p_lo_d  = mag_b_s;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
`ifdef MUL_DIV_UNIT_DIV_EN
                if (is_div(op_q)) begin
                    if (!div_trial_s[WIDTH]) begin
                        p_hi_d = div_trial_s[WIDTH-1:0];
                        p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_hi_d = {p_hi_q[WIDTH-2:0], p_lo_q[WIDTH-1]};
                        p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    p_hi_d = mul_sum_s[WIDTH:1];
                    p_lo_d = {mul_sum_s[0], p_lo_q[WIDTH-1:1]};
                end
`else
                p_hi_d = mul_sum_s[WIDTH:1];
                p_lo_d = {mul_sum_s[0], p_lo_q[WIDTH-1:1]};
`endif
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dbz_d   = 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
                if (is_div(op_q)) begin
                    lo_d  = quo_fix_s;
                    hi_d  = rem_fix_s;
                    // Magnitude divide already yields MOST_NEG / 0 here;
                    // only the flag needs raising.
                    ovf_d = (op_q == OP_DIV) && (a_q == MOST_NEG) && (b_q == {WIDTH{1'b1}});
                end else begin
                    {hi_d, lo_d} = prod_fix_s;
                    ovf_d        = 1'b0;
                end
`else
                {hi_d, lo_d} = prod_fix_s;
                ovf_d        = 1'b0;
`endif
                z_d = (hi_d == ZERO_W) && (lo_d == ZERO_W);
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lo_q      <= {WIDTH{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            z_q       <= 1'b1;
            op_q      <= OP_MULTU;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            m_q       <= {WIDTH{1'b0}};
            p_hi_q    <= {WIDTH{1'b0}};
            p_lo_q    <= {WIDTH{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            neg_res_q <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
            z_q       <= z_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            p_hi_q    <= p_hi_d;
            p_lo_q    <= p_lo_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
`ifdef MUL_DIV_UNIT_DIV_EN
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.lo   = lo_q;
    assign bus.hi   = hi_q;
    assign bus.dbz  = dbz_q;
    assign bus.ovf  = ovf_q;
    assign bus.z    = z_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
// Self-checking bench for mul_div_unit (WIDTH=32). Expected results come from
// a plain-arithmetic reference model; divide expectations follow the
// MUL_DIV_UNIT_DIV_EN build option.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        logic         ovf;
        logic         z;
    } res_t;

    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: full-precision product; truncating divide, remainder
    // follows the dividend's sign.
    function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        res_t               r;
        logic        [63:0] p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] m;
        r  = '0;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b00: begin
                p = {32'd0, a} * {32'd0, b};
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'b10: begin
                p = sa * sb;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            default: begin
`ifdef MUL_DIV_UNIT_DIV_EN
                if (b == 32'd0) begin
                    r.dbz = 1'b1;
                end else if (op == 2'b01) begin
                    r.lo = a / b;
                    r.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.lo  = 32'h8000_0000;
                    r.ovf = 1'b1;
                end else begin
                    q = sa / sb;
                    m = sa % sb;
                    r.lo = q[31:0];
                    r.hi = m[31:0];
                end
`else
                r.ovf = 1'b1;
`endif
            end
        endcase
        r.z = (r.hi == 32'd0) && (r.lo == 32'd0);
        return r;
    endfunction

    // Edges from acceptance to done.
    function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
        if (op[0] == 1'b0) return W + 2;
`ifdef MUL_DIV_UNIT_DIV_EN
        if (b == 32'd0) return 2;
        return W + 2;
`else
        return 2;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    // Launch one op (called #1 after an edge), scramble inputs after
    // acceptance, optionally pulse start at E0+poke_at, wait for done.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int poke_at, input string tag);
        res_t e;
        int   cyc;
        logic busy_ok;
        e = model(op, a, b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.in1   = a;
        bus.in2   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.in1   = 32'($urandom);
        bus.in2   = 32'($urandom);
        cyc     = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < 200) begin
            if (cyc == poke_at - 1) bus.start = 1'b1;
            else                    bus.start = 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat(op, b)));
        check({tag, "_busy_during"}, {63'd0, busy_ok}, 64'd1);
        check({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
        check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, e.lo});
        check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, e.hi});
        check({tag, "_dbz"}, {63'd0, bus.dbz}, {63'd0, e.dbz});
        check({tag, "_ovf"}, {63'd0, bus.ovf}, {63'd0, e.ovf});
        check({tag, "_z"}, {63'd0, bus.z}, {63'd0, e.z});
    endtask

    // Run n cycles with start low; done must never appear.
    task automatic idle_check(input int n, input string tag);
        int seen = 0;
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
        check({tag, "_done"}, {63'd0, bus.done}, 64'd0);
        check({tag, "_lo"}, {32'd0, bus.lo}, 64'd0);
        check({tag, "_hi"}, {32'd0, bus.hi}, 64'd0);
        check({tag, "_dbz"}, {63'd0, bus.dbz}, 64'd0);
        check({tag, "_ovf"}, {63'd0, bus.ovf}, 64'd0);
        check({tag, "_z"}, {63'd0, bus.z}, 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.in1   = 32'd0;
        bus.in2   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-width unsigned product, done at E0+34.
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
        check("multu_max_hi_const", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFE);
        check("multu_max_lo_const", {32'd0, bus.lo}, 64'h0000_0000_0000_0001);

        // Signed multiplies, back-to-back from the done cycle.
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, -1, "mult_m3x5");
        check("mult_m3x5_hi_const", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFF);
        check("mult_m3x5_lo_const", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFF1);
        run_op(2'b10, 32'd0, 32'hFFFF_FFFF, -1, "mult_0xm1");

        // Divides and their corner cases.
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, "div_m7d2");
`ifdef MUL_DIV_UNIT_DIV_EN
        check("div_m7d2_lo_const", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFD);
        check("div_m7d2_hi_const", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFF);
`endif
        run_op(2'b01, 32'd7, 32'd2, -1, "divu_7d2");
        run_op(2'b01, 32'd5, 32'd0, -1, "divu_5d0");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        run_op(2'b00, 32'd6, 32'd7, -1, "multu_after_flags");

        // Start pulsed mid-operation is ignored: one done, nothing after.
        run_op(2'b10, 32'd1234, 32'hFFFF_FF00, 5, "poke");
        idle_check(W + 6, "poke_single_done");

        // Reset mid-operation aborts without a done.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.in1   = 32'h1234_5678;
        bus.in2   = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        @(posedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        idle_check(W + 4, "midrst_no_done");
        run_op(2'b10, 32'h7FFF_FFFF, 32'h8000_0000, -1, "after_rst");

        // Randomized back-to-back operations.
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), pick(), pick(), -1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
